// File: rtl/dport_fill_master.sv
// Data-port initiator: writes a seed+k pattern block (FILL) or reads it back and checks it (VERIFY).
// Optional macro DPORT_FILL_FLUSH_EN adds a flush request after a FILL has drained.
module dport_fill_master #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_W           = 16,
  parameter int TAG_W           = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      seed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [LEN_W-1:0] mismatch_cnt_o,
  output logic [31:0]      mem_d_addr_o,
  output logic [31:0]      mem_d_data_wr_o,
  output logic             mem_d_rd_o,
  output logic [3:0]       mem_d_wr_o,
  output logic             mem_d_cacheable_o,
  output logic [TAG_W-1:0] mem_d_req_tag_o,
  output logic             mem_d_invalidate_o,
  output logic             mem_d_writeback_o,
  output logic             mem_d_flush_o,
  input  logic [31:0]      mem_d_data_rd_i,
  input  logic             mem_d_accept_i,
  input  logic             mem_d_ack_i,
  input  logic             mem_d_error_i,
  input  logic [TAG_W-1:0] mem_d_resp_tag_i
);

  localparam int OW = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
`ifdef DPORT_FILL_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] issued, acked, len_q, mism_q;
  logic [OW-1:0]    outs, outs_nx;
  logic             mode_q, err_q;
  logic [31:0]      base_q, seed_q;
`ifdef DPORT_FILL_FLUSH_EN
  logic             flush_sent;
`endif

  logic             req_vld, acc, in_op, in_flush, flush_vld, flush_acc;
  logic             good, spurious, tag_bad, data_bad;
  logic [TAG_W-1:0] exp_tag;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    req_vld   = (state == ISSUE) && (issued < len_q) && (outs < OW'(MAX_OUTSTANDING));
    acc       = req_vld && mem_d_accept_i;
    in_op     = (state == ISSUE) || (state == DRAIN);
    in_flush  = 1'b0;
    flush_vld = 1'b0;
`ifdef DPORT_FILL_FLUSH_EN
    in_flush  = (state == FLUSH);
    flush_vld = in_flush && !flush_sent;
    in_op     = in_op || in_flush;
`endif
    flush_acc = flush_vld && mem_d_accept_i;
    // Acks outside an operation belong to an aborted run and are dropped.
    good      = in_op && mem_d_ack_i && (outs != '0);
    spurious  = in_op && mem_d_ack_i && (outs == '0);
    exp_tag   = in_flush ? '0 : TAG_W'(acked);
    tag_bad   = good && (mem_d_resp_tag_i != exp_tag);
    data_bad  = good && mode_q && !in_flush &&
                (mem_d_error_i || (mem_d_data_rd_i != seed_q + 32'(acked)));
    outs_nx   = outs + {{(OW-1){1'b0}}, (acc | flush_acc)} - {{(OW-1){1'b0}}, good};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_i) state_nx = (len_i == '0) ? DONE : ISSUE;
      ISSUE: if (acc && (issued + 1'b1 == len_q)) state_nx = DRAIN;
      DRAIN: begin
        if (outs_nx == '0) begin
`ifdef DPORT_FILL_FLUSH_EN
          state_nx = mode_q ? DONE : FLUSH;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef DPORT_FILL_FLUSH_EN
      FLUSH: if (flush_sent && good) state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      issued <= '0;
      acked  <= '0;
      outs   <= '0;
      err_q  <= 1'b0;
      mism_q <= '0;
`ifdef DPORT_FILL_FLUSH_EN
      flush_sent <= 1'b0;
`endif
    end else if (state == IDLE && start_i) begin
      issued <= '0;
      acked  <= '0;
      outs   <= '0;
      err_q  <= 1'b0;
      mism_q <= '0;
`ifdef DPORT_FILL_FLUSH_EN
      flush_sent <= 1'b0;
`endif
    end else begin
      if (acc) issued <= issued + 1'b1;
      if (good && !in_flush) acked <= acked + 1'b1;
      outs <= outs_nx;
      if (spurious || tag_bad || (good && mem_d_error_i) || data_bad) err_q <= 1'b1;
      if (data_bad) mism_q <= sat_inc(mism_q);
`ifdef DPORT_FILL_FLUSH_EN
      if (flush_acc) flush_sent <= 1'b1;
`endif
    end
  end

  // Operation parameters are plain data: captured on start, never reset.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) begin
      mode_q <= mode_i;
      base_q <= base_addr_i & 32'hFFFF_FFFC;
      len_q  <= len_i;
      seed_q <= seed_i;
    end
  end

  assign busy_o             = (state != IDLE);
  assign done_o             = (state == DONE);
  assign error_o            = err_q;
  assign mismatch_cnt_o     = mism_q;
  assign mem_d_addr_o       = req_vld ? base_q + (32'(issued) << 2) : 32'h0;
  assign mem_d_data_wr_o    = (req_vld && !mode_q) ? seed_q + 32'(issued) : 32'h0;
  assign mem_d_rd_o         = req_vld && mode_q;
  assign mem_d_wr_o         = {4{req_vld && !mode_q}};
  assign mem_d_req_tag_o    = req_vld ? TAG_W'(issued) : '0;
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = flush_vld;

endmodule
